// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-controller handshakes around mem_arbiter.
// The master modport is the arbiter's view; slave is the requester/controller side.
interface mem_arbiter_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_flush;
    logic        ifu_done;
    logic [31:0] ifu_inst;
    logic [31:0] ifu_pc;

    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;

    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        input  ifu_req, ifu_addr, ifu_flush,
        output ifu_done, ifu_inst, ifu_pc,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output lsu_done, lsu_rdata,
        output mc_req, mc_we, mc_addr, mc_wdata,
        input  mc_done, mc_rdata
    );

    modport slave (
        output ifu_req, ifu_addr, ifu_flush,
        input  ifu_done, ifu_inst, ifu_pc,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  lsu_done, lsu_rdata,
        input  mc_req, mc_we, mc_addr, mc_wdata,
        output mc_done, mc_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory-controller port between IFU and LSU, one 32-bit transaction
// at a time; LSU has priority, bounded by a starvation limit; IFU fetches can be flushed.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output logic          busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic        owner_ifu;
    logic        discard;
    logic [3:0]  starve_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rsp_data;
    logic [31:0] ifu_inst_q;
    logic [31:0] ifu_pc_q;
    logic [31:0] lsu_rdata_q;

    logic grant_ifu;
    logic grant_lsu;
    logic ifu_deliver;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        grant_ifu   = bus.ifu_req && (!bus.lsu_req || starve_cnt == LIMIT);
        grant_lsu   = bus.lsu_req && !grant_ifu;
        // A flush landing in the DONE cycle itself must still swallow the pulse.
        ifu_deliver = (state == DONE) && owner_ifu && !discard && !bus.ifu_flush;
    end

    assign busy          = (state != IDLE);
    assign bus.mc_req    = (state == ISSUE);
    assign bus.mc_we     = lat_we;
    assign bus.mc_addr   = lat_addr;
    assign bus.mc_wdata  = lat_wdata;
    assign bus.lsu_done  = (state == DONE) && !owner_ifu;
    assign bus.lsu_rdata = lsu_rdata_q;
    assign bus.ifu_done  = ifu_deliver;
    assign bus.ifu_inst  = ifu_deliver ? rsp_data : ifu_inst_q;
    assign bus.ifu_pc    = ifu_deliver ? lat_addr : ifu_pc_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_ifu   <= 1'b0;
            discard     <= 1'b0;
            starve_cnt  <= 4'd0;
            lat_we      <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            rsp_data    <= 32'd0;
            ifu_inst_q  <= 32'd0;
            ifu_pc_q    <= 32'd0;
            lsu_rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        state     <= ISSUE;
                        owner_ifu <= grant_ifu;
                        discard   <= grant_ifu && bus.ifu_flush;
                        lat_we    <= grant_lsu && bus.lsu_we;
                        lat_addr  <= grant_ifu ? bus.ifu_addr : bus.lsu_addr;
                        lat_wdata <= grant_ifu ? 32'd0 : bus.lsu_wdata;
                        if (grant_ifu || !bus.ifu_req)
                            starve_cnt <= 4'd0;
                        else if (starve_cnt != 4'hF)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    discard <= discard | (owner_ifu & bus.ifu_flush);
                end
                WAIT: begin
                    discard <= discard | (owner_ifu & bus.ifu_flush);
                    if (bus.mc_done) begin
                        state    <= DONE;
                        rsp_data <= bus.mc_rdata;
                        if (!owner_ifu && !lat_we)
                            lsu_rdata_q <= bus.mc_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    discard <= 1'b0;
                    if (ifu_deliver) begin
                        ifu_inst_q <= rsp_data;
                        ifu_pc_q   <= lat_addr;
                    end
                end
            endcase
        end
    end
endmodule
